// File: rtl/seven_segment_to_byte.sv
// Recovers a byte from the 14 segment lines driving two hex digits: waits for a stable
// pattern, decodes each digit back to a nibble and strobes the result once per new pattern.
module seven_segment_to_byte #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Segment1_A,
    input  logic       i_Segment1_B,
    input  logic       i_Segment1_C,
    input  logic       i_Segment1_D,
    input  logic       i_Segment1_E,
    input  logic       i_Segment1_F,
    input  logic       i_Segment1_G,
    input  logic       i_Segment2_A,
    input  logic       i_Segment2_B,
    input  logic       i_Segment2_C,
    input  logic       i_Segment2_D,
    input  logic       i_Segment2_E,
    input  logic       i_Segment2_F,
    input  logic       i_Segment2_G,
    output logic [7:0] o_Byte,
    output logic       o_Valid,
    output logic       o_Error
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT,
        S_ACCEPT,
        S_HOLD
    } state_t;

    logic [13:0]   pins;
    logic [13:0]   segIn;
    logic [13:0]   seg_q, prev_q;
    logic [13:0]   last_d, last_q;
    logic [CW-1:0] cnt_d, cnt_q;
    state_t        state_d, state_q;
    logic [7:0]    byte_d, byte_q;
    logic          valid_d, valid_q;
    logic          error_d, error_q;
    logic          changed;
    logic [4:0]    decHi, decLo;

    // Bit order per digit is A..G from MSB to LSB; digit 1 occupies the upper seven bits.
    assign pins = {i_Segment1_A, i_Segment1_B, i_Segment1_C, i_Segment1_D,
                   i_Segment1_E, i_Segment1_F, i_Segment1_G,
                   i_Segment2_A, i_Segment2_B, i_Segment2_C, i_Segment2_D,
                   i_Segment2_E, i_Segment2_F, i_Segment2_G};
    assign segIn = SEG_ACTIVE_LOW ? ~pins : pins;

    // Returns {illegal, nibble}; an unrecognised code decodes as nibble 0.
    function automatic logic [4:0] decodeDigit(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    assign decHi   = decodeDigit(seg_q[13:7]);
    assign decLo   = decodeDigit(seg_q[6:0]);
    assign changed = (seg_q != prev_q);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            seg_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
            last_q  <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            seg_q   <= segIn;
            prev_q  <= seg_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // An all-off last pattern doubles as "nothing accepted", since blank is never accepted.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        last_d  = last_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        error_d = error_q;

        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_WAIT: begin
                if (!changed && cnt_d == CNT_MAX) begin
                    state_d = S_ACCEPT;
                    if (seg_q == '0) begin
                        last_d = '0;
                    end else if (seg_q != last_q) begin
                        last_d  = seg_q;
                        valid_d = 1'b1;
                        byte_d  = {decHi[3:0], decLo[3:0]};
                        error_d = decHi[4] | decLo[4];
                    end
                end
            end
            S_ACCEPT: begin
                state_d = changed ? S_WAIT : S_HOLD;
            end
            S_HOLD: begin
                if (changed) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign o_Byte  = byte_q;
    assign o_Valid = valid_q;
    assign o_Error = error_q;

endmodule

// File: tb/tb_seven_segment_to_byte.sv
// Directed bench for seven_segment_to_byte: an active-high and an active-low instance see
// the same logical patterns and are both checked against hand-computed expectations.
module tb_seven_segment_to_byte;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg1 = 7'b0;
    logic [6:0] seg2 = 7'b0;
    logic [6:0] nSeg1, nSeg2;
    logic [7:0] byteHi, byteLo;
    logic       validHi, validLo, errHi, errLo;

    int vectors = 0;
    int miscompares = 0;
    int edgeCnt = 0;
    int startEdge = 0;
    int strobesHi = 0, strobesLo = 0;
    int lastEdgeHi = 0, lastEdgeLo = 0;
    logic [7:0] lastByteHi = 8'h00, lastByteLo = 8'h00;
    logic       lastErrHi = 1'b0, lastErrLo = 1'b0;
    logic       sweepErrHi = 1'b0, sweepErrLo = 1'b0;
    int s0Hi, s0Lo;

    assign nSeg1 = ~seg1;
    assign nSeg2 = ~seg2;

    always #5 clk = ~clk;

    seven_segment_to_byte #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) u_dutHi (
        .i_Clk(clk), .i_Rst(rst),
        .i_Segment1_A(seg1[6]), .i_Segment1_B(seg1[5]), .i_Segment1_C(seg1[4]),
        .i_Segment1_D(seg1[3]), .i_Segment1_E(seg1[2]), .i_Segment1_F(seg1[1]),
        .i_Segment1_G(seg1[0]),
        .i_Segment2_A(seg2[6]), .i_Segment2_B(seg2[5]), .i_Segment2_C(seg2[4]),
        .i_Segment2_D(seg2[3]), .i_Segment2_E(seg2[2]), .i_Segment2_F(seg2[1]),
        .i_Segment2_G(seg2[0]),
        .o_Byte(byteHi), .o_Valid(validHi), .o_Error(errHi)
    );

    seven_segment_to_byte #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) u_dutLo (
        .i_Clk(clk), .i_Rst(rst),
        .i_Segment1_A(nSeg1[6]), .i_Segment1_B(nSeg1[5]), .i_Segment1_C(nSeg1[4]),
        .i_Segment1_D(nSeg1[3]), .i_Segment1_E(nSeg1[2]), .i_Segment1_F(nSeg1[1]),
        .i_Segment1_G(nSeg1[0]),
        .i_Segment2_A(nSeg2[6]), .i_Segment2_B(nSeg2[5]), .i_Segment2_C(nSeg2[4]),
        .i_Segment2_D(nSeg2[3]), .i_Segment2_E(nSeg2[2]), .i_Segment2_F(nSeg2[1]),
        .i_Segment2_G(nSeg2[0]),
        .o_Byte(byteLo), .o_Valid(validLo), .o_Error(errLo)
    );

    // Record every strobe with the edge number it followed.
    always @(posedge clk) begin
        edgeCnt++;
        #1;
        if (validHi) begin
            strobesHi++;
            lastEdgeHi = edgeCnt;
            lastByteHi = byteHi;
            lastErrHi  = errHi;
            if (errHi) sweepErrHi = 1'b1;
        end
        if (validLo) begin
            strobesLo++;
            lastEdgeLo = edgeCnt;
            lastByteLo = byteLo;
            lastErrLo  = errLo;
            if (errLo) sweepErrLo = 1'b1;
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        return t[n];
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkBoth(input string tag, input int aHi, input int aLo, input int expected);
        checkOutput({tag, "_hi"}, aHi, expected);
        checkOutput({tag, "_lo"}, aLo, expected);
    endtask

    task automatic applyStimulus(input logic [6:0] d1, input logic [6:0] d2, input int cycles);
        @(negedge clk);
        seg1 = d1;
        seg2 = d2;
        startEdge = edgeCnt;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic applyByte(input logic [7:0] b, input int cycles);
        applyStimulus(enc(b[7:4]), enc(b[3:0]), cycles);
    endtask

    task automatic snap();
        s0Hi = strobesHi;
        s0Lo = strobesLo;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkBoth("rstByte",  byteHi,  byteLo,  8'h00);
        checkBoth("rstValid", validHi, validLo, 0);
        checkBoth("rstError", errHi,   errLo,   0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // "3","C": one strobe five edges after the first sample, then silence.
        snap();
        applyByte(8'h3C, 106);
        checkBoth("t1Count",   strobesHi - s0Hi, strobesLo - s0Lo, 1);
        checkBoth("t1Latency", lastEdgeHi - startEdge, lastEdgeLo - startEdge, 6);
        checkBoth("t1Byte",    lastByteHi, lastByteLo, 8'h3C);
        checkBoth("t1Error",   lastErrHi,  lastErrLo,  0);

        // Loopback sweep of every byte value.
        sweepErrHi = 1'b0;
        sweepErrLo = 1'b0;
        for (int b = 0; b < 256; b++) begin
            snap();
            applyByte(8'(b), 10);
            checkBoth($sformatf("sweepCnt%0h", b),  strobesHi - s0Hi, strobesLo - s0Lo, 1);
            checkBoth($sformatf("sweepByte%0h", b), lastByteHi, lastByteLo, b);
        end
        checkBoth("sweepError", sweepErrHi, sweepErrLo, 0);

        // Glitch to 77 and back to the accepted 3C is invisible; a held 77 is not.
        applyByte(8'h3C, 15);
        snap();
        applyByte(8'h77, 3);
        applyByte(8'h3C, 20);
        checkBoth("t3Glitch", strobesHi - s0Hi, strobesLo - s0Lo, 0);
        checkBoth("t3Hold",   byteHi, byteLo, 8'h3C);
        snap();
        applyByte(8'h77, 20);
        checkBoth("t3Count", strobesHi - s0Hi, strobesLo - s0Lo, 1);
        checkBoth("t3Byte",  lastByteHi, lastByteLo, 8'h77);

        // Illegal upper digit decodes as 0 with the error flag; a legal pattern clears it.
        snap();
        applyStimulus(7'b1010101, enc(4'h5), 20);
        checkBoth("t4Count", strobesHi - s0Hi, strobesLo - s0Lo, 1);
        checkBoth("t4Byte",  lastByteHi, lastByteLo, 8'h05);
        checkBoth("t4Error", lastErrHi,  lastErrLo,  1);
        checkBoth("t4ErrHeld", errHi, errLo, 1);
        applyByte(8'h12, 20);
        checkBoth("t4Byte2",  lastByteHi, lastByteLo, 8'h12);
        checkBoth("t4Error2", lastErrHi,  lastErrLo,  0);

        // Blank never strobes but lets the same value be reported again.
        snap();
        applyByte(8'hA5, 20);
        checkBoth("t5First", strobesHi - s0Hi, strobesLo - s0Lo, 1);
        snap();
        applyStimulus(7'b0, 7'b0, 10);
        checkBoth("t5Blank",     strobesHi - s0Hi, strobesLo - s0Lo, 0);
        checkBoth("t5BlankByte", byteHi, byteLo, 8'hA5);
        applyByte(8'hA5, 20);
        checkBoth("t5Again",     strobesHi - s0Hi, strobesLo - s0Lo, 1);
        checkBoth("t5AgainByte", lastByteHi, lastByteLo, 8'hA5);

        // Reset with the counter at 3 aborts; the held pattern is reported after release.
        snap();
        applyByte(8'h5A, 5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkBoth("t6RstByte",  byteHi,  byteLo,  8'h00);
        checkBoth("t6RstValid", validHi, validLo, 0);
        rst = 1'b0;
        startEdge = edgeCnt;
        checkBoth("t6NoStrobe", strobesHi - s0Hi, strobesLo - s0Lo, 0);
        repeat (20) @(posedge clk);
        checkBoth("t6Count",   strobesHi - s0Hi, strobesLo - s0Lo, 1);
        checkBoth("t6Latency", lastEdgeHi - startEdge, lastEdgeLo - startEdge, 6);
        checkBoth("t6Byte",    lastByteHi, lastByteLo, 8'h5A);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
